// File: rtl/counter_rr_sched.sv
// Round-robin scheduler that shares one saturating event counter among NREQ requesters.
// Define COUNTER_SCHED_FORMAL_EN to embed per-cycle immediate assertions on the counter and grant.
module counter_rr_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 10,
    parameter int INIT  = 5,
    parameter int LIMIT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] cnt,
    output logic             full,
    output logic [1:0]       state,
    output logic [2:0]       last_id
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SAT  = 2'd2;

    localparam logic [WIDTH-1:0] INIT_W  = INIT[WIDTH-1:0];
    localparam logic [WIDTH:0]   LIMIT_W = LIMIT[WIDTH:0];

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic             full_reg;
    logic [2:0]       ptr_reg;
    logic [2:0]       last_id_reg;

    logic       grant_ok;
    logic [7:0] req_pad;
    logic [7:0] gnt_pad;
    logic [2:0] win_next;
    logic       found;
    logic [3:0] idx;
    logic [2:0] ptr_next;
    logic [WIDTH:0] sum_next;

    assign grant_ok = (state_reg == ST_RUN) && en && !clr && (|req);
    assign req_pad  = 8'(req);

    // Scan upward from ptr, wrapping at NREQ; the first set request wins.
    always_comb begin
        gnt_pad  = '0;
        win_next = '0;
        found    = 1'b0;
        idx      = '0;
        if (grant_ok) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = {1'b0, ptr_reg} + 4'(k);
                if (idx >= 4'(NREQ))
                    idx = idx - 4'(NREQ);
                if (!found && req_pad[idx[2:0]]) begin
                    found            = 1'b1;
                    gnt_pad[idx[2:0]] = 1'b1;
                    win_next         = idx[2:0];
                end
            end
        end
    end

    assign ptr_next = (win_next == 3'(NREQ - 1)) ? 3'd0 : win_next + 3'd1;
    assign sum_next = {1'b0, cnt_reg} + {{WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= INIT_W;
            full_reg    <= 1'b0;
            ptr_reg     <= '0;
            last_id_reg <= '0;
        end else if (clr) begin
            // Clear keeps ptr so fairness carries across the clear.
            cnt_reg   <= INIT_W;
            full_reg  <= 1'b0;
            state_reg <= en ? ST_RUN : ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (en)
                        state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (!en) begin
                        state_reg <= ST_IDLE;
                    end else if (found) begin
                        cnt_reg     <= sum_next[WIDTH-1:0];
                        ptr_reg     <= ptr_next;
                        last_id_reg <= win_next;
                        if (sum_next == LIMIT_W) begin
                            full_reg  <= 1'b1;
                            state_reg <= ST_SAT;
                        end
                    end
                end
                ST_SAT: state_reg <= ST_SAT;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign gnt     = gnt_pad[NREQ-1:0];
    assign cnt     = cnt_reg;
    assign full    = full_reg;
    assign state   = state_reg;
    assign last_id = last_id_reg;

`ifdef COUNTER_SCHED_FORMAL_EN
    logic init_done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            init_done_reg <= 1'b0;
        else
            init_done_reg <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_n && init_done_reg) begin
            assert ({1'b0, cnt_reg} <= LIMIT_W);
            assert (cnt_reg >= INIT_W);
            assert ($onehot0(gnt));
            assert ((gnt & ~req) == '0);
            assert (full_reg == ({1'b0, cnt_reg} == LIMIT_W));
            assert (state_reg != 2'd3);
            assert (gnt == '0 || state_reg == ST_RUN);
        end
    end
`endif

endmodule

// File: tb/tb_counter_rr_sched.sv
// Directed-vector bench for counter_rr_sched with hand-computed expectations.
module tb_counter_rr_sched;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [9:0] cnt;
    logic       full;
    logic [1:0] state;
    logic [2:0] last_id;

    int total;
    int bad;

    counter_rr_sched #(.NREQ(4), .WIDTH(10), .INIT(5), .LIMIT(1023)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req),
        .gnt(gnt), .cnt(cnt), .full(full), .state(state), .last_id(last_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s value=%0d", tag, got);
        end
    endtask

    // Advance one clock edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq2 [5];

    initial begin
        total = 0;
        bad   = 0;
        seq2[0] = 4'b0001; seq2[1] = 4'b0010; seq2[2] = 4'b0100;
        seq2[3] = 4'b1000; seq2[4] = 4'b0001;

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; req = 4'b0000;
        step();
        step();
        chk("rst_cnt", 32'(cnt), 5);
        chk("rst_state", 32'(state), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_last_id", 32'(last_id), 0);
        chk("rst_gnt", 32'(gnt), 0);
        rst_n = 1'b1;

        // 1: enable with no requests
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_state", 32'(state), 1);
            chk("t1_gnt", 32'(gnt), 0);
            chk("t1_cnt", 32'(cnt), 5);
        end

        // 2: all requesting, rotation from ptr=0
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_gnt", 32'(gnt), 32'(seq2[i]));
            step();
            chk("t2_cnt", 32'(cnt), 32'(6 + i));
        end
        chk("t2_last_id", 32'(last_id), 0);

        // 3: lone requester 2 granted every cycle
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_gnt", 32'(gnt), 32'(4'b0100));
            step();
            chk("t3_cnt", 32'(cnt), 32'(11 + i));
            chk("t3_last_id", 32'(last_id), 2);
        end

        // 4: run up to saturation with requester 0
        req = 4'b0001;
        for (int i = 0; i < 1009; i++)
            step();
        chk("t4_cnt_1022", 32'(cnt), 1022);
        chk("t4_full_pre", 32'(full), 0);
        chk("t4_state_pre", 32'(state), 1);
        #1;
        chk("t4_gnt_last", 32'(gnt), 32'(4'b0001));
        step();
        chk("t4_cnt_sat", 32'(cnt), 1023);
        chk("t4_full", 32'(full), 1);
        chk("t4_state_sat", 32'(state), 2);
        chk("t4_last_id", 32'(last_id), 0);
        chk("t4_gnt_sat", 32'(gnt), 0);
        step();
        chk("t4_cnt_hold", 32'(cnt), 1023);
        en = 1'b0;
        step();
        chk("t4_state_en0", 32'(state), 2);

        // 5: clear out of SAT with en=1; ptr kept at 1
        en = 1'b1; clr = 1'b1; req = 4'b1111;
        #1;
        chk("t5_gnt_clr", 32'(gnt), 0);
        step();
        clr = 1'b0;
        chk("t5_cnt", 32'(cnt), 5);
        chk("t5_full", 32'(full), 0);
        chk("t5_state", 32'(state), 1);
        #1;
        chk("t5_gnt_resume", 32'(gnt), 32'(4'b0010));
        step();
        chk("t5_cnt_inc", 32'(cnt), 6);
        chk("t5_last_id", 32'(last_id), 1);

        // en=0 in RUN returns to IDLE without counting
        en = 1'b0;
        step();
        chk("t5_idle", 32'(state), 0);
        chk("t5_idle_cnt", 32'(cnt), 6);
        en = 1'b1;
        step();
        chk("t5_rerun", 32'(state), 1);

        // 6: count to 40, then asynchronous reset mid-cycle
        for (int i = 0; i < 34; i++)
            step();
        chk("t6_cnt40", 32'(cnt), 40);
        #1;
        chk("t6_gnt_pre", 32'(gnt) != 0 ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_gnt_rst", 32'(gnt), 0);
        chk("t6_cnt_rst", 32'(cnt), 5);
        chk("t6_state_rst", 32'(state), 0);
        chk("t6_full_rst", 32'(full), 0);
        chk("t6_last_id_rst", 32'(last_id), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_state_run", 32'(state), 1);
        #1;
        chk("t6_gnt_ptr0", 32'(gnt), 32'(4'b0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
